// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode/issue stage in front of the EX-stage ALU. It decodes RV32I OP, OP-IMM,
// LUI and AUIPC instructions into a 4-bit ALU operation code and two operands.
// The result is registered behind a valid/ready handshake with a latency of one
// cycle. An instruction this stage cannot decode is still issued, with
// o_illegal set, so that the exception is raised downstream.
//
// ALU code map: 0000 nop, 0001 add, 0010 sub, 0011 sll, 0100 slt, 0101 sltu,
//               0110 xor, 0111 srl, 1000 sra, 1001 or, 1010 and.
//
// Ports
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   i_valid        upstream bundle valid
//   o_ready        this stage can accept (combinational: !o_valid | i_ready)
//   i_instr        instruction word
//   i_pc           instruction PC, used as the AUIPC operand
//   i_rs1_data     rs1 register value
//   i_rs2_data     rs2 register value
//   i_flush        drop the held bundle and refuse the incoming one
//   o_valid        issued bundle valid toward the ALU
//   i_ready        downstream accepts the bundle
//   o_data1        ALU operand 1
//   o_data2        ALU operand 2
//   o_alu_control  ALU operation code
//   o_illegal      instruction not decodable by this stage
// -----------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data1,
  output logic [WIDTH-1:0] o_data2,
  output logic [3:0]       o_alu_control,
  output logic             o_illegal
);

  typedef enum logic [3:0] {
    ALU_NOP  = 4'b0000,
    ALU_ADD  = 4'b0001,
    ALU_SUB  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_XOR  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_OR   = 4'b1001,
    ALU_AND  = 4'b1010
  } alu_op_e;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ---------------------------------------------------------------------------
  // Instruction fields
  // ---------------------------------------------------------------------------
  logic [6:0]       opcode;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic [WIDTH-1:0] imm_i;
  logic [WIDTH-1:0] imm_u;

  assign opcode = i_instr[6:0];
  assign f3     = i_instr[14:12];
  assign f7     = i_instr[31:25];
  assign imm_i  = {{(WIDTH-12){i_instr[31]}}, i_instr[31:20]};
  assign imm_u  = {i_instr[31:12], 12'b0};

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  alu_op_e          dec_op;
  logic [WIDTH-1:0] dec_data1;
  logic [WIDTH-1:0] dec_data2;
  logic             dec_illegal;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path through
    // the case statements can leave a signal unassigned and infer a latch.
    dec_op      = ALU_NOP;
    dec_data1   = '0;
    dec_data2   = '0;
    dec_illegal = 1'b0;

    unique case (opcode)
      OPC_OP: begin
        dec_data1 = i_rs1_data;
        dec_data2 = i_rs2_data;
        if (f7 == F7_BASE) begin
          unique case (f3)
            3'b000: dec_op = ALU_ADD;
            3'b001: dec_op = ALU_SLL;
            3'b010: dec_op = ALU_SLT;
            3'b011: dec_op = ALU_SLTU;
            3'b100: dec_op = ALU_XOR;
            3'b101: dec_op = ALU_SRL;
            3'b110: dec_op = ALU_OR;
            default: dec_op = ALU_AND;
          endcase
        end else if (f7 == F7_ALT && f3 == 3'b000) begin
          dec_op = ALU_SUB;
        end else if (f7 == F7_ALT && f3 == 3'b101) begin
          dec_op = ALU_SRA;
        end else begin
          // Includes the M extension (f7 = 0000001), which this ALU does not run.
          dec_illegal = 1'b1;
        end
      end

      OPC_OPIMM: begin
        dec_data1 = i_rs1_data;
        dec_data2 = imm_i;
        unique case (f3)
          3'b000: dec_op = ALU_ADD;
          3'b010: dec_op = ALU_SLT;
          3'b011: dec_op = ALU_SLTU;
          3'b100: dec_op = ALU_XOR;
          3'b110: dec_op = ALU_OR;
          3'b111: dec_op = ALU_AND;
          3'b001: begin
            if (f7 == F7_BASE) dec_op = ALU_SLL;
            else               dec_illegal = 1'b1;
          end
          default: begin // 3'b101
            if      (f7 == F7_BASE) dec_op = ALU_SRL;
            else if (f7 == F7_ALT)  dec_op = ALU_SRA;
            else                    dec_illegal = 1'b1;
          end
        endcase
      end

      OPC_LUI: begin
        dec_op    = ALU_ADD;
        dec_data2 = imm_u;
      end

      OPC_AUIPC: begin
        dec_op    = ALU_ADD;
        dec_data1 = i_pc;
        dec_data2 = imm_u;
      end

      default: dec_illegal = 1'b1;
    endcase

    // The ALU shifter only looks at a 5-bit amount; mask it here so operand 2
    // carries exactly the shift amount for both register and immediate forms.
    if (dec_op == ALU_SLL || dec_op == ALU_SRL || dec_op == ALU_SRA) begin
      dec_data2 = {{(WIDTH-5){1'b0}}, dec_data2[4:0]};
    end

    // Illegal bundles travel with zeroed operands and a no-op code.
    if (dec_illegal) begin
      dec_op    = ALU_NOP;
      dec_data1 = '0;
      dec_data2 = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and output register
  // ---------------------------------------------------------------------------
  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] data1_q,   data1_d;
  logic [WIDTH-1:0] data2_q,   data2_d;
  logic [3:0]       ctrl_q,    ctrl_d;
  logic             illegal_q, illegal_d;
  logic             accept;

  assign o_ready = !valid_q || i_ready;
  // Flush wins over acceptance but deliberately does not gate o_ready.
  assign accept  = i_valid && o_ready && !i_flush;

  always_comb begin
    valid_d   = valid_q;
    data1_d   = data1_q;
    data2_d   = data2_q;
    ctrl_d    = ctrl_q;
    illegal_d = illegal_q;

    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      // Covers accept-with-transfer too: the new bundle replaces the old one.
      valid_d   = 1'b1;
      data1_d   = dec_data1;
      data2_d   = dec_data2;
      ctrl_d    = dec_op;
      illegal_d = dec_illegal;
    end else if (valid_q && i_ready) begin
      // Transfer out with nothing behind it; data registers keep stale values.
      valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values and the block order cannot change the result.
  // NOTE: the operand registers are reset as well as valid, because the reset
  // state of every output is defined, not only the valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      data1_q   <= '0;
      data2_q   <= '0;
      ctrl_q    <= ALU_NOP;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      data1_q   <= data1_d;
      data2_q   <= data2_d;
      ctrl_q    <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end

  assign o_valid       = valid_q;
  assign o_data1       = data1_q;
  assign o_data2       = data2_q;
  assign o_alu_control = ctrl_q;
  assign o_illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Directed self-checking bench for alu_issue_stage. Inputs change 1 ns after
// the rising edge; outputs are sampled at that same point, well away from the
// next active edge. Expected values are hand-computed from the instruction
// encodings.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic [31:0] i_rs1_data;
  logic [31:0] i_rs2_data;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_data1;
  logic [31:0] o_data2;
  logic [3:0]  o_alu_control;
  logic        o_illegal;

  int n_checks;
  int n_errors;

  alu_issue_stage #(.WIDTH(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_instr       (i_instr),
    .i_pc          (i_pc),
    .i_rs1_data    (i_rs1_data),
    .i_rs2_data    (i_rs2_data),
    .i_flush       (i_flush),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_data1       (o_data1),
    .o_data2       (o_data2),
    .o_alu_control (o_alu_control),
    .o_illegal     (o_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction for a single cycle (downstream ready), then check
  // the registered bundle.
  task automatic issue(input string tag, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [3:0] exp_ctrl,
                       input logic [31:0] exp_d1, input logic [31:0] exp_d2,
                       input logic exp_ill);
    i_valid    = 1'b1;
    i_instr    = instr;
    i_pc       = pc;
    i_rs1_data = rs1;
    i_rs2_data = rs2;
    tick();
    i_valid = 1'b0;
    check({tag, ".valid"}, {31'b0, o_valid},   32'd1);
    check({tag, ".ctrl"},  {28'b0, o_alu_control}, {28'b0, exp_ctrl});
    check({tag, ".d1"},    o_data1, exp_d1);
    check({tag, ".d2"},    o_data2, exp_d2);
    check({tag, ".ill"},   {31'b0, o_illegal}, {31'b0, exp_ill});
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_instr    = 32'h0;
    i_pc       = 32'h0;
    i_rs1_data = 32'h0;
    i_rs2_data = 32'h0;
    i_flush    = 1'b0;
    i_ready    = 1'b1;

    // ---------------- reset and idle ----------------
    #12;
    check("rst.valid", {31'b0, o_valid}, 32'd0);
    check("rst.ctrl",  {28'b0, o_alu_control}, 32'd0);
    check("rst.d1",    o_data1, 32'd0);
    check("rst.d2",    o_data2, 32'd0);
    check("rst.ill",   {31'b0, o_illegal}, 32'd0);
    check("rst.ready", {31'b0, o_ready}, 32'd1);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle.valid", {31'b0, o_valid}, 32'd0);
    check("idle.ctrl",  {28'b0, o_alu_control}, 32'd0);

    // ---------------- decode vectors ----------------
    //        tag      instr         pc          rs1           rs2          ctrl   d1            d2            ill
    issue("sub",    32'h40208033, 32'h0,     32'd5,        32'd7,        4'h2, 32'd5,        32'd7,        1'b0);
    issue("srai",   32'h4030D093, 32'h0,     32'h80000000, 32'h0,        4'h8, 32'h80000000, 32'd3,        1'b0);
    issue("sll",    32'h003110B3, 32'h0,     32'h11,       32'h25,       4'h3, 32'h11,       32'd5,        1'b0);
    issue("slli",   32'h00509093, 32'h0,     32'h22,       32'h0,        4'h3, 32'h22,       32'd5,        1'b0);
    issue("sltiu",  32'hFFF0B093, 32'h0,     32'd9,        32'h0,        4'h5, 32'd9,        32'hFFFFFFFF, 1'b0);
    issue("and",    32'h003170B3, 32'h0,     32'hF0F0F0F0, 32'h0FF00FF0, 4'hA, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
    issue("mul",    32'h02208033, 32'h0,     32'd5,        32'd7,        4'h0, 32'd0,        32'd0,        1'b1);
    issue("auipc",  32'h00001017, 32'h100,   32'hDEAD,     32'h0,        4'h1, 32'h100,      32'h1000,     1'b0);
    issue("lui",    32'h12345037, 32'h100,   32'hBEEF,     32'h0,        4'h1, 32'd0,        32'h12345000, 1'b0);
    issue("badopc", 32'h0000007F, 32'h0,     32'd1,        32'd2,        4'h0, 32'd0,        32'd0,        1'b1);
    issue("slli7",  32'h40509093, 32'h0,     32'd1,        32'd2,        4'h0, 32'd0,        32'd0,        1'b1);

    // Transfer out with nothing new: valid drops.
    tick();
    check("drain.valid", {31'b0, o_valid}, 32'd0);

    // ---------------- backpressure ----------------
    i_ready    = 1'b0;
    i_valid    = 1'b1;
    i_instr    = 32'hFFF00093;       // addi x1,x0,-1
    i_rs1_data = 32'h0;
    tick();
    i_instr    = 32'h40208033;       // sub waits behind it
    i_rs1_data = 32'd20;
    i_rs2_data = 32'd6;
    for (int i = 0; i < 3; i++) begin
      check("bp.valid", {31'b0, o_valid}, 32'd1);
      check("bp.ctrl",  {28'b0, o_alu_control}, 32'd1);
      check("bp.d2",    o_data2, 32'hFFFFFFFF);
      check("bp.ready", {31'b0, o_ready}, 32'd0);
      tick();
    end
    i_ready = 1'b1;
    #1;
    check("bp.release_ready", {31'b0, o_ready}, 32'd1);
    tick();
    // addi transferred and sub accepted on the same edge.
    check("b2b0.valid", {31'b0, o_valid}, 32'd1);
    check("b2b0.ctrl",  {28'b0, o_alu_control}, 32'd2);
    check("b2b0.d1",    o_data1, 32'd20);
    i_instr = 32'h003140B3;          // xor x1,x2,x3
    i_rs1_data = 32'hAAAA0000;
    i_rs2_data = 32'h0000BBBB;
    tick();
    check("b2b1.valid", {31'b0, o_valid}, 32'd1);
    check("b2b1.ctrl",  {28'b0, o_alu_control}, 32'd6);
    check("b2b1.d2",    o_data2, 32'h0000BBBB);
    i_valid = 1'b0;
    tick();
    check("b2b2.valid", {31'b0, o_valid}, 32'd0);

    // ---------------- flush ----------------
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_instr = 32'hFFF00093;
    tick();
    check("fl.held", {31'b0, o_valid}, 32'd1);
    i_instr = 32'h40208033;
    i_flush = 1'b1;
    #1;
    check("fl.ready_bp", {31'b0, o_ready}, 32'd0);
    i_ready = 1'b1;
    #1;
    check("fl.ready", {31'b0, o_ready}, 32'd1);
    tick();
    i_flush = 1'b0;
    i_valid = 1'b0;
    check("fl.valid", {31'b0, o_valid}, 32'd0);
    tick();
    check("fl.not_issued", {31'b0, o_valid}, 32'd0);

    // ---------------- async reset mid-transfer ----------------
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_instr = 32'h40208033;
    i_rs1_data = 32'd5;
    i_rs2_data = 32'd7;
    tick();
    i_valid = 1'b0;
    check("ar.held", {31'b0, o_valid}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar.valid", {31'b0, o_valid}, 32'd0);
    check("ar.ctrl",  {28'b0, o_alu_control}, 32'd0);
    check("ar.d1",    o_data1, 32'd0);
    rst_n = 1'b1;
    tick();
    check("ar.after", {31'b0, o_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
